// File: rtl/scope_trace_buffer.sv
// Triggered, double-banked ADC trace buffer: captures around a rising-edge trigger into one bank
// while the video side reads a frozen, complete capture from the other; banks swap on frame_start.
module scope_trace_buffer #(
    parameter int DATA_W  = 12,
    parameter int DEPTH   = 1280,
    parameter int ADDR_W  = 11,
    parameter int PRETRIG = 640,
    parameter int DECIM   = 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_enable,
    input  logic              frame_start,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_col,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              trace_ready,
    output logic [1:0]        state_out
);

    typedef enum logic [1:0] {
        S_FILL  = 2'b00,
        S_ARMED = 2'b01,
        S_POST  = 2'b10,
        S_HOLD  = 2'b11
    } state_t;

    localparam int DC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DC_W-1:0]   DEC_LAST = DC_W'(DECIM - 1);
    localparam logic [DC_W-1:0]   DEC_ONE  = DC_W'(1);
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   PRE_TGT  = (ADDR_W+1)'(PRETRIG);
    localparam logic [ADDR_W:0]   POST_TOT = (ADDR_W+1)'(DEPTH - PRETRIG);
    localparam logic [ADDR_W:0]   ONE_X    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PRE_A    = ADDR_W'(PRETRIG);
    localparam logic [ADDR_W-1:0] POST_A   = ADDR_W'(DEPTH - PRETRIG);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DC_W-1:0]     r_decim_cnt;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W:0]     r_pre_cnt;
    logic [ADDR_W:0]     r_post_cnt;
    logic [ADDR_W-1:0]   r_trig_ptr;
    logic [DATA_W-1:0]   r_prev_sample;
    logic                r_wr_bank;
    logic                r_disp_bank;
    logic [ADDR_W-1:0]   r_disp_start;
    logic                r_disp_valid;
    logic [DATA_W-1:0]   r_mem [0:2*DEPTH-1];
    logic [ADDR_W:0]     r_rd_idx;
    logic                r_rd_oob;
    logic                r_rd_en1;
    logic                r_rd_valid;
    logic                r_rd_zero;
    logic [DATA_W-1:0]   r_ram_q;

    logic                w_accept;
    logic                w_store;
    logic                w_trig;
    logic                w_swap;
    logic [ADDR_W-1:0]   w_cap_start;
    logic [ADDR_W:0]     w_wr_idx;
    logic [ADDR_W:0]     w_rd_sum;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [ADDR_W:0]     w_rd_idx;
    logic                w_rd_oob;

    assign w_accept = sample_valid && (r_state != S_HOLD);
    assign w_store  = w_accept && (r_decim_cnt == DEC_LAST);
    assign w_trig   = w_store && (r_state == S_ARMED) &&
                      (!trig_enable || ((sample_in >= trig_level) && (r_prev_sample < trig_level)));
    assign w_swap   = (r_state == S_HOLD) && frame_start;

    // Oldest pre-trigger sample sits PRETRIG slots behind the trigger, modulo the ring size.
    assign w_cap_start = (r_trig_ptr >= PRE_A) ? (r_trig_ptr - PRE_A) : (r_trig_ptr + POST_A);
    assign w_wr_idx    = r_wr_bank ? ({1'b0, r_wr_ptr} + DEPTH_X) : {1'b0, r_wr_ptr};

    // Next-state logic for the capture sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL: begin
                if ((r_pre_cnt >= PRE_TGT) || (w_store && ((r_pre_cnt + ONE_X) >= PRE_TGT)))
                    w_state_nxt = S_ARMED;
                else
                    w_state_nxt = S_FILL;
            end
            S_ARMED: begin
                if (w_trig)
                    w_state_nxt = (POST_TOT == ONE_X) ? S_HOLD : S_POST;
                else
                    w_state_nxt = S_ARMED;
            end
            S_POST: begin
                if (w_store && ((r_post_cnt + ONE_X) == POST_TOT))
                    w_state_nxt = S_HOLD;
                else
                    w_state_nxt = S_POST;
            end
            S_HOLD: begin
                if (frame_start)
                    w_state_nxt = S_FILL;
                else
                    w_state_nxt = S_HOLD;
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Capture-side state, counters and bank bookkeeping
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state       <= S_FILL;
            r_decim_cnt   <= '0;
            r_wr_ptr      <= '0;
            r_pre_cnt     <= '0;
            r_post_cnt    <= '0;
            r_trig_ptr    <= '0;
            r_prev_sample <= '0;
            r_wr_bank     <= 1'b0;
            r_disp_bank   <= 1'b0;
            r_disp_start  <= '0;
            r_disp_valid  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_swap) begin
                r_disp_bank  <= r_wr_bank;
                r_disp_start <= w_cap_start;
                r_disp_valid <= 1'b1;
                r_wr_bank    <= ~r_wr_bank;
                r_wr_ptr     <= '0;
                r_pre_cnt    <= '0;
                r_decim_cnt  <= '0;
            end else begin
                if (w_accept)
                    r_decim_cnt <= (r_decim_cnt == DEC_LAST) ? '0 : (r_decim_cnt + DEC_ONE);
                if (w_store) begin
                    r_wr_ptr      <= (r_wr_ptr == PTR_LAST) ? '0 : (r_wr_ptr + PTR_ONE);
                    r_prev_sample <= sample_in;
                    if ((r_state == S_FILL) && (r_pre_cnt < PRE_TGT))
                        r_pre_cnt <= r_pre_cnt + ONE_X;
                    if (r_state == S_POST)
                        r_post_cnt <= r_post_cnt + ONE_X;
                end
                if (w_trig) begin
                    r_trig_ptr <= r_wr_ptr;
                    r_post_cnt <= ONE_X;
                end
            end
        end
    end

    // Sample memory write port
    always_ff @(posedge clk_in) begin
        if (w_store)
            r_mem[w_wr_idx] <= sample_in;
    end

    assign w_rd_sum  = {1'b0, r_disp_start} + {1'b0, rd_col};
    assign w_rd_addr = (w_rd_sum >= DEPTH_X) ? ADDR_W'(w_rd_sum - DEPTH_X) : ADDR_W'(w_rd_sum);
    assign w_rd_oob  = ({1'b0, rd_col} >= DEPTH_X);
    // Out-of-range columns are parked on address 0 so the RAM index stays in bounds.
    assign w_rd_idx  = w_rd_oob ? '0 :
                       (r_disp_bank ? ({1'b0, w_rd_addr} + DEPTH_X) : {1'b0, w_rd_addr});

    // Read pipeline control: address stage, then data-qualify stage
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_rd_idx   <= '0;
            r_rd_oob   <= 1'b0;
            r_rd_en1   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_zero  <= 1'b1;
        end else begin
            r_rd_idx   <= w_rd_idx;
            r_rd_oob   <= w_rd_oob;
            r_rd_en1   <= rd_en;
            r_rd_valid <= r_rd_en1;
            r_rd_zero  <= r_rd_oob || !r_disp_valid;
        end
    end

    // Registered RAM read port
    always_ff @(posedge clk_in) begin
        r_ram_q <= r_mem[r_rd_idx];
    end

    assign rd_data     = r_rd_zero ? '0 : r_ram_q;
    assign rd_valid    = r_rd_valid;
    assign trace_ready = r_disp_valid;
    assign state_out   = r_state;

endmodule

// File: tb/tb_scope_trace_buffer.sv
// Directed bench for scope_trace_buffer: edge-triggered and free-run captures, bank swap,
// read-pipe latency and range handling, decimation, and asynchronous reset.
module tb_scope_trace_buffer;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [11:0] sample_in, trig_level;
    logic        sample_valid, trig_enable, frame_start, rd_en;
    logic [10:0] rd_col;
    logic [11:0] rd_data;
    logic        rd_valid, trace_ready;
    logic [1:0]  state_out;

    logic [11:0] d_sample;
    logic        d_valid, d_frame, d_rd_en;
    logic [10:0] d_rd_col;
    logic [11:0] d_rd_data;
    logic        d_rd_valid, d_trace_ready;
    logic [1:0]  d_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    scope_trace_buffer u_dut (
        .clk_in(clk_in), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .trig_level(trig_level), .trig_enable(trig_enable), .frame_start(frame_start),
        .rd_en(rd_en), .rd_col(rd_col), .rd_data(rd_data), .rd_valid(rd_valid),
        .trace_ready(trace_ready), .state_out(state_out)
    );

    scope_trace_buffer #(.DECIM(4)) u_dec (
        .clk_in(clk_in), .reset(reset), .sample_in(d_sample), .sample_valid(d_valid),
        .trig_level(trig_level), .trig_enable(trig_enable), .frame_start(d_frame),
        .rd_en(d_rd_en), .rd_col(d_rd_col), .rd_data(d_rd_data), .rd_valid(d_rd_valid),
        .trace_ready(d_trace_ready), .state_out(d_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [11:0] v);
        sample_in = v;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic dpush(input logic [11:0] v);
        d_sample = v;
        d_valid = 1'b1;
        step();
        d_valid = 1'b0;
    endtask

    task automatic fpulse();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic rd(input logic [10:0] col, input logic [11:0] exp, input string tag);
        rd_en = 1'b1;
        rd_col = col;
        step();
        rd_en = 1'b0;
        chk({tag, "_valid_early"}, {31'd0, rd_valid}, 32'd0);
        step();
        chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        chk(tag, {20'd0, rd_data}, {20'd0, exp});
    endtask

    task automatic drd(input logic [10:0] col, input logic [11:0] exp, input string tag);
        d_rd_en = 1'b1;
        d_rd_col = col;
        step();
        d_rd_en = 1'b0;
        step();
        chk({tag, "_valid"}, {31'd0, d_rd_valid}, 32'd1);
        chk(tag, {20'd0, d_rd_data}, {20'd0, exp});
    endtask

    initial begin
        reset = 1'b1;
        sample_in = 12'd0; sample_valid = 1'b0; trig_level = 12'd2000; trig_enable = 1'b1;
        frame_start = 1'b0; rd_en = 1'b0; rd_col = 11'd0;
        d_sample = 12'd0; d_valid = 1'b0; d_frame = 1'b0; d_rd_en = 1'b0; d_rd_col = 11'd0;
        repeat (3) step();
        chk("rst_state", {30'd0, state_out}, 32'd0);
        chk("rst_ready", {31'd0, trace_ready}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data", {20'd0, rd_data}, 32'd0);
        reset = 1'b0;
        step();

        // Edge trigger on a ramp of step 8, one strobe every 4 clocks
        for (int k = 0; k < 1401; k++) begin
            push(12'((8 * k) % 4096));
            if (k == 5) begin
                rd(11'd5, 12'd0, "pre_swap_rd");
                chk("pre_swap_ready", {31'd0, trace_ready}, 32'd0);
            end
            if (k == 699) begin
                chk("armed_state", {30'd0, state_out}, 32'd1);
                fpulse();
                chk("armed_fs_ignored", {30'd0, state_out}, 32'd1);
                chk("armed_fs_ready", {31'd0, trace_ready}, 32'd0);
            end
            repeat (3) step();
        end
        chk("ramp_post", {30'd0, state_out}, 32'd2);
        push(12'd3016);
        chk("ramp_hold", {30'd0, state_out}, 32'd3);
        push(12'h555);
        chk("hold_state", {30'd0, state_out}, 32'd3);
        chk("hold_ready", {31'd0, trace_ready}, 32'd0);
        sample_in = 12'hABC; sample_valid = 1'b1; frame_start = 1'b1;
        step();
        sample_valid = 1'b0; frame_start = 1'b0;
        chk("swap1_state", {30'd0, state_out}, 32'd0);
        chk("swap1_ready", {31'd0, trace_ready}, 32'd1);
        rd(11'd640, 12'd2000, "ramp_col640");
        rd(11'd639, 12'd1992, "ramp_col639");
        rd(11'd0, 12'd976, "ramp_col0");
        rd(11'd1279, 12'd3016, "ramp_col1279");
        rd(11'd1280, 12'd0, "oob_1280");
        rd(11'd2047, 12'd0, "oob_2047");

        // Free-run capture of a constant
        trig_enable = 1'b0;
        for (int i = 0; i < 1279; i++) push(12'h123);
        chk("free_post", {30'd0, state_out}, 32'd2);
        push(12'h123);
        chk("free_hold", {30'd0, state_out}, 32'd3);
        fpulse();
        chk("swap2_state", {30'd0, state_out}, 32'd0);
        for (int c = 0; c < 1280; c++) rd(11'(c), 12'h123, "const_col");

        // Edge trigger after the ring has wrapped: trigger at pointer 360, cap_start 1000
        trig_enable = 1'b1;
        for (int k = 0; k < 2280; k++) begin
            push((k < 1640) ? 12'(k) : ((k == 1640) ? 12'd2500 : 12'(3000 + k - 1640)));
            if (k == 1000) begin
                chk("below_level_armed", {30'd0, state_out}, 32'd1);
                fpulse();
                chk("below_level_no_swap", {30'd0, state_out}, 32'd1);
                chk("below_level_ready", {31'd0, trace_ready}, 32'd1);
                rd(11'd7, 12'h123, "disp_frozen");
            end
            if (k == 1640) chk("wrap_trig_post", {30'd0, state_out}, 32'd2);
        end
        chk("wrap_hold", {30'd0, state_out}, 32'd3);
        fpulse();
        rd(11'd1279, 12'd3639, "wrap_col1279");
        rd(11'd640, 12'd2500, "wrap_col640");
        rd(11'd0, 12'd1000, "wrap_col0");
        rd(11'd639, 12'd1639, "wrap_col639");
        rd(11'd1280, 12'd0, "wrap_oob");

        // Asynchronous reset during POST
        trig_enable = 1'b0;
        for (int i = 0; i < 700; i++) push(12'h0F0);
        chk("pre_reset_post", {30'd0, state_out}, 32'd2);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_state", {30'd0, state_out}, 32'd0);
        chk("async_rst_ready", {31'd0, trace_ready}, 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // Decimation by 4 on a +1 ramp
        for (int s = 0; s < 5120; s++) begin
            dpush(12'(s % 4096));
            if (s == 5118) chk("dec_post", {30'd0, d_state}, 32'd2);
        end
        chk("dec_hold", {30'd0, d_state}, 32'd3);
        d_frame = 1'b1;
        step();
        d_frame = 1'b0;
        chk("dec_ready", {31'd0, d_trace_ready}, 32'd1);
        drd(11'd0, 12'd3, "dec_col0");
        drd(11'd1, 12'd7, "dec_col1");
        drd(11'd10, 12'd43, "dec_col10");
        drd(11'd11, 12'd47, "dec_col11");
        drd(11'd640, 12'd2563, "dec_col640");
        drd(11'd1279, 12'd1023, "dec_col1279");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
